// File: rtl/ps2_bridge_pkg.sv
// rtl/ps2_bridge_pkg.sv - shared types, header layout and entry layout for the PS/2-to-UART event bridge (PS2_UART_CHECKSUM_EN)
package ps2_bridge_pkg;

    // Header byte bit positions
    localparam int HDR_MARK  = 7;
    localparam int HDR_CH_HI = 6;
    localparam int HDR_CH_LO = 4;
    localparam int HDR_OVF   = 3;
    localparam int HDR_INT   = 2;
    localparam int HDR_FULL  = 1;
    localparam int HDR_ONE   = 0;

    // FIFO entry = {ch_id[2:0], int, data[7:0]}
    localparam int ENTRY_W   = 12;
    localparam int ENT_CH_HI = 11;
    localparam int ENT_CH_LO = 9;
    localparam int ENT_INT   = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR_LOAD,
        ST_HDR_START,
        ST_HDR_WAIT,
        ST_DAT_LOAD,
        ST_DAT_START,
        ST_DAT_WAIT
`ifdef PS2_UART_CHECKSUM_EN
        ,
        ST_SUM_LOAD,
        ST_SUM_START,
        ST_SUM_WAIT
`endif
    } tx_state_e;

    function automatic logic [7:0] make_hdr(input logic [2:0] ch, input logic ovf,
                                            input logic intf, input logic full);
        logic [7:0] h;
        h                      = '0;
        h[HDR_MARK]            = 1'b1;
        h[HDR_CH_HI:HDR_CH_LO] = ch;
        h[HDR_OVF]             = ovf;
        h[HDR_INT]             = intf;
        h[HDR_FULL]            = full;
        h[HDR_ONE]             = 1'b1;
        return h;
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - synchronous event FIFO with full/empty flags and wrap-around pointers
module ps2_evt_fifo
    import ps2_bridge_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; contents are don't-care until the pointers say otherwise
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ps2_uart_event_bridge.sv
// rtl/ps2_uart_event_bridge.sv - multi-channel PS/2 event collector framing packets to uart_tx (PS2_UART_CHECKSUM_EN adds a checksum byte)
module ps2_uart_event_bridge
    import ps2_bridge_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CH_W       = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   ev_valid,
    input  logic [8*NUM_CH-1:0] ev_data,
    input  logic [NUM_CH-1:0]   ch_int,
    input  logic                tx_busy,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    input  logic                ovf_clear,
    output logic                overflow,
    output logic [7:0]          drop_cnt,
    output logic                pending
);

    logic [NUM_CH-1:0]  hold_vld_q;
    logic [NUM_CH-1:0]  hold_int_q;
    logic [7:0]         hold_data_q [NUM_CH];
    logic [NUM_CH-1:0]  grant;
    logic [NUM_CH-1:0]  accept;
    logic [NUM_CH-1:0]  drop;
    logic [CH_W-1:0]    rr_ptr_q;
    logic [CH_W-1:0]    rr_ptr_d;
    logic [CH_W-1:0]    win_ch;
    logic               win_found;
    logic               win_int;
    logic [7:0]         win_data;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;

    logic               overflow_q;
    logic [7:0]         drop_cnt_q;
    logic [3:0]         ndrop;
    logic [8:0]         cnt_sum;

    tx_state_e          state_q;
    logic [ENTRY_W-1:0] ent_q;
    logic               full_at_pop_q;
    logic               tx_start_q;
    logic [7:0]         tx_data_q;
`ifdef PS2_UART_CHECKSUM_EN
    logic [7:0]         hdr_q;
`endif

    // Round-robin search for the first occupied hold starting at the pointer
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_ch    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            for (int c = 0; c < NUM_CH; c++) begin
                if (!win_found && c == idx && hold_vld_q[c]) begin
                    win_found = 1'b1;
                    win_ch    = CH_W'(c);
                end
            end
        end
    end

    // Winner mux, grant, accept/drop decisions and next round-robin pointer
    always_comb begin
        win_data  = '0;
        win_int   = 1'b0;
        grant     = '0;
        fifo_push = win_found & ~fifo_full;
        for (int c = 0; c < NUM_CH; c++) begin
            if (win_ch == CH_W'(c)) begin
                win_data = hold_data_q[c];
                win_int  = hold_int_q[c];
                grant[c] = fifo_push;
            end
        end
        accept   = ev_valid & (~hold_vld_q | grant);
        drop     = ev_valid & hold_vld_q & ~grant;
        rr_ptr_d = rr_ptr_q;
        if (fifo_push) begin
            rr_ptr_d = (int'(win_ch) + 1 >= NUM_CH) ? '0 : win_ch + CH_W'(1);
        end
    end

    assign fifo_wdata = {win_ch, win_int, win_data};
    assign fifo_pop   = (state_q == ST_IDLE) & ~fifo_empty;

    // Per-channel hold registers and arbiter pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld_q <= '0;
            hold_int_q <= '0;
            rr_ptr_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) hold_data_q[c] <= '0;
        end else begin
            hold_vld_q <= (hold_vld_q & ~grant) | accept;
            rr_ptr_q   <= rr_ptr_d;
            for (int c = 0; c < NUM_CH; c++) begin
                if (accept[c]) begin
                    hold_data_q[c] <= ev_data[8*c +: 8];
                    hold_int_q[c]  <= ch_int[c];
                end
            end
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Number of drops this cycle and the saturated running total
    always_comb begin
        ndrop = '0;
        for (int c = 0; c < NUM_CH; c++) ndrop = ndrop + 4'(drop[c]);
        cnt_sum = {1'b0, drop_cnt_q} + 9'(ndrop);
    end

    // Overflow sticky and drop counter; a drop in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (|drop) begin
            overflow_q <= 1'b1;
            if (ovf_clear)          drop_cnt_q <= 8'(ndrop);
            else if (cnt_sum[8])    drop_cnt_q <= 8'hFF;
            else                    drop_cnt_q <= cnt_sum[7:0];
        end else if (ovf_clear) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end
    end

    // Packet transmit FSM; tx_start is high during the first WAIT cycle, which doubles as the busy-latency guard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ent_q         <= '0;
            full_at_pop_q <= 1'b0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
`ifdef PS2_UART_CHECKSUM_EN
            hdr_q         <= '0;
`endif
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        ent_q         <= fifo_rdata;
                        full_at_pop_q <= fifo_full;
                        state_q       <= ST_HDR_LOAD;
                    end
                end
                ST_HDR_LOAD: begin
                    tx_data_q <= make_hdr(ent_q[ENT_CH_HI:ENT_CH_LO], overflow_q,
                                          ent_q[ENT_INT], full_at_pop_q);
`ifdef PS2_UART_CHECKSUM_EN
                    hdr_q     <= make_hdr(ent_q[ENT_CH_HI:ENT_CH_LO], overflow_q,
                                          ent_q[ENT_INT], full_at_pop_q);
`endif
                    state_q   <= ST_HDR_START;
                end
                ST_HDR_START: begin
                    tx_start_q <= 1'b1;
                    state_q    <= ST_HDR_WAIT;
                end
                ST_HDR_WAIT: begin
                    if (!tx_start_q && !tx_busy) state_q <= ST_DAT_LOAD;
                end
                ST_DAT_LOAD: begin
                    tx_data_q <= ent_q[7:0];
                    state_q   <= ST_DAT_START;
                end
                ST_DAT_START: begin
                    tx_start_q <= 1'b1;
                    state_q    <= ST_DAT_WAIT;
                end
                ST_DAT_WAIT: begin
`ifdef PS2_UART_CHECKSUM_EN
                    if (!tx_start_q && !tx_busy) state_q <= ST_SUM_LOAD;
`else
                    if (!tx_start_q && !tx_busy) state_q <= ST_IDLE;
`endif
                end
`ifdef PS2_UART_CHECKSUM_EN
                ST_SUM_LOAD: begin
                    tx_data_q <= hdr_q ^ ent_q[7:0];
                    state_q   <= ST_SUM_START;
                end
                ST_SUM_START: begin
                    tx_start_q <= 1'b1;
                    state_q    <= ST_SUM_WAIT;
                end
                ST_SUM_WAIT: begin
                    if (!tx_start_q && !tx_busy) state_q <= ST_IDLE;
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;
    assign pending  = ~fifo_empty | (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_uart_event_bridge.sv
// tb/tb_ps2_uart_event_bridge.sv - directed self-checking bench for ps2_uart_event_bridge
module tb_ps2_uart_event_bridge;

`ifdef PS2_UART_CHECKSUM_EN
    localparam int PKT_LEN = 3;
`else
    localparam int PKT_LEN = 2;
`endif
    localparam int BUSY_CYC = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  ev_valid = '0;
    logic [15:0] ev_data = '0;
    logic [1:0]  ch_int = '0;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        ovf_clear = 1'b0;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        pending;

    logic        stall = 1'b0;
    int          busy_cnt = 0;
    int          n_start = 0;
    logic [7:0]  cap_q [$];
    logic [7:0]  exp_q [$];
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    ps2_uart_event_bridge #(
        .NUM_CH     (2),
        .FIFO_DEPTH (4),
        .CH_W       (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ev_valid  (ev_valid),
        .ev_data   (ev_data),
        .ch_int    (ch_int),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .ovf_clear (ovf_clear),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .pending   (pending)
    );

    // uart_tx model: latch the byte on tx_start, stay busy for BUSY_CYC cycles
    assign tx_busy = stall | (busy_cnt != 0);
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else if (tx_start) begin
            cap_q.push_back(tx_data);
            n_start  = n_start + 1;
            busy_cnt = BUSY_CYC;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic exp_pkt(input logic [7:0] hdr, input logic [7:0] dat);
        exp_q.push_back(hdr);
        exp_q.push_back(dat);
`ifdef PS2_UART_CHECKSUM_EN
        exp_q.push_back(hdr ^ dat);
`endif
    endtask

    task automatic check_bytes(input string tag);
        check({tag, "_count"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < cap_q.size()) check($sformatf("%s_byte%0d", tag, i), cap_q[i], exp_q[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        stall = 1'b0;
        ev_valid = '0;
        ovf_clear = 1'b0;
        repeat (2) @(negedge clk);
        cap_q.delete();
        exp_q.delete();
        n_start = 0;
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [1:0] i);
        @(negedge clk);
        ev_valid = v;
        ev_data  = {d1, d0};
        ch_int   = i;
        @(negedge clk);
        ev_valid = '0;
        ch_int   = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (pending === 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, pending, 1'b0);
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_overflow", overflow, 1'b0);
        check("rst_drop_cnt", drop_cnt, 8'h00);
        check("rst_pending", pending, 1'b0);
        do_reset();

        // Single ch1 event with interrupt flag
        send(2'b10, 8'h00, 8'h1C, 2'b10);
        @(negedge clk);
        check("t1_pending_hi", pending, 1'b1);
        wait_idle("t1");
        check("t1_busy_at_idle", tx_busy, 1'b0);
        check("t1_starts", n_start, PKT_LEN);
        exp_pkt(8'h95, 8'h1C);
        check_bytes("t1");

        // Simultaneous pair: ch0 first, then round robin favours ch1 after a ch0 win
        do_reset();
        send(2'b11, 8'h11, 8'h22, 2'b00);
        wait_idle("t2a");
        exp_pkt(8'h81, 8'h11);
        exp_pkt(8'h91, 8'h22);
        send(2'b01, 8'h33, 8'h00, 2'b00);
        wait_idle("t2b");
        exp_pkt(8'h81, 8'h33);
        send(2'b11, 8'h44, 8'h55, 2'b00);
        wait_idle("t2c");
        exp_pkt(8'h91, 8'h55);
        exp_pkt(8'h81, 8'h44);
        check_bytes("t2");

        // Stalled uart: FSM holds ev1, FIFO ev2..ev5, hold ev6, ev7/ev8 dropped
        do_reset();
        stall = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            send(2'b01, 8'(8'h30 + k), 8'h00, 2'b00);
            @(negedge clk);
        end
        check("t3_drop_cnt", drop_cnt, 8'd2);
        check("t3_overflow", overflow, 1'b1);
        check("t3_pending", pending, 1'b1);
        stall = 1'b0;
        wait_idle("t3");
        exp_pkt(8'h81, 8'h31);
        exp_pkt(8'h8B, 8'h32);
        exp_pkt(8'h8B, 8'h33);
        exp_pkt(8'h89, 8'h34);
        exp_pkt(8'h89, 8'h35);
        exp_pkt(8'h89, 8'h36);
        check_bytes("t3");

        // Drop counter saturation, clear, and drop-beats-clear
        do_reset();
        stall = 1'b1;
        for (int k = 0; k < 306; k++) send(2'b01, 8'(k), 8'h00, 2'b00);
        check("t4_sat_cnt", drop_cnt, 8'd255);
        check("t4_sat_ovf", overflow, 1'b1);
        @(negedge clk);
        ovf_clear = 1'b1;
        @(negedge clk);
        ovf_clear = 1'b0;
        check("t4_clr_ovf", overflow, 1'b0);
        check("t4_clr_cnt", drop_cnt, 8'd0);
        ev_valid  = 2'b01;
        ovf_clear = 1'b1;
        @(negedge clk);
        ev_valid  = '0;
        ovf_clear = 1'b0;
        check("t4_race_ovf", overflow, 1'b1);
        check("t4_race_cnt", drop_cnt, 8'd1);

        // Reset in the middle of the data byte
        do_reset();
        send(2'b01, 8'h5A, 8'h00, 2'b00);
        begin
            int n;
            n = 0;
            while (n_start < 2 && n < 500) begin
                @(negedge clk);
                n++;
            end
            check("t5_reach_data", n_start, 2);
        end
        repeat (3) @(negedge clk);
        check("t5_pending_before", pending, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_tx_start", tx_start, 1'b0);
        check("t5_rst_pending", pending, 1'b0);
        check("t5_rst_tx_data", tx_data, 8'h00);
        repeat (2) @(negedge clk);
        cap_q.delete();
        exp_q.delete();
        n_start = 0;
        rst_n = 1'b1;
        send(2'b10, 8'h00, 8'h77, 2'b00);
        wait_idle("t5");
        exp_pkt(8'h91, 8'h77);
        check_bytes("t5");

        // ch0 0x1C, no interrupt
        do_reset();
        send(2'b01, 8'h1C, 8'h00, 2'b00);
        wait_idle("t6");
        exp_pkt(8'h81, 8'h1C);
        check_bytes("t6");
`ifdef PS2_UART_CHECKSUM_EN
        if (cap_q.size() >= 3) check("t6_checksum", cap_q[2], 8'h9D);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
